// File: rtl/output_harness_pkg.sv
// Shared definitions for the output harness: frame FSM encoding and the
// frame-length helper that benches use to align frames.
package output_harness_pkg;

  typedef enum logic [1:0] {
    START  = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_e;

  // Cycles per frame: one start bit, BITS data bits, one parity bit.
  function automatic int unsigned frame_len(input int unsigned bits);
    return bits + 32'd2;
  endfunction

endpackage

// File: rtl/output_harness.sv
// output_harness: folds a BITS-wide bus into one serial pin so every input bit
// of every cycle stays observable. Words are XOR-accumulated between frames;
// each frame is a start bit, the accumulated word LSB-first, then even parity.
// Ports:
//   fast_clk          in   clock, all state on rising edge
//   rst_n             in   synchronous active-low reset
//   data_on_fast_clk  in   BITS-wide data word, sampled every cycle
//   pin_on_fast_clk   out  registered serial output
//   frame_start       out  registered, high while the pin carries a start bit
module output_harness
  import output_harness_pkg::*;
#(
  parameter int unsigned BITS = 64
) (
  input  logic            fast_clk,
  input  logic            rst_n,
  input  logic [BITS-1:0] data_on_fast_clk,
  output logic            pin_on_fast_clk,
  output logic            frame_start
);

  localparam int unsigned CNT_W = $clog2(BITS + 1);

  state_e             state_q, state_d;
  logic [BITS-1:0]    acc_q, acc_d;
  logic [BITS-1:0]    shreg_q, shreg_d;
  logic               par_q, par_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pin_q, pin_d;
  logic               fs_q, fs_d;
  logic [BITS-1:0]    w;

  // Current word folded into whatever has accumulated since the last launch.
  assign w = acc_q ^ data_on_fast_clk;

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    cnt_d   = cnt_q;
    pin_d   = pin_q;
    fs_d    = 1'b0;
    unique case (state_q)
      START: begin
        pin_d   = 1'b1;
        fs_d    = 1'b1;
        shreg_d = w;
        par_d   = ^w;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = DATA;
      end
      DATA: begin
        pin_d   = shreg_q[0];
        shreg_d = shreg_q >> 1;
        acc_d   = w;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BITS - 1)) state_d = PARITY;
      end
      PARITY: begin
        pin_d   = par_q;
        acc_d   = w;
        state_d = START;
      end
      default: state_d = START;
    endcase
  end

  // State and output registers; reset wins over any transition.
  always_ff @(posedge fast_clk) begin
    if (!rst_n) begin
      state_q <= START;
      acc_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      cnt_q   <= '0;
      pin_q   <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
      pin_q   <= pin_d;
      fs_q    <= fs_d;
    end
  end

  assign pin_on_fast_clk = pin_q;
  assign frame_start     = fs_q;

endmodule

// File: tb/tb_output_harness.sv
// Self-checking bench for output_harness at BITS=8 (directed frames),
// BITS=1 (minimum width) and BITS=64 (random data against a frame model).
module tb_output_harness;
  import output_harness_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8, rst1, rst64;
  logic [7:0]  d8;
  logic [0:0]  d1;
  logic [63:0] d64;
  logic        pin8, fs8, pin1, fs1, pin64, fs64;

  output_harness #(.BITS(8)) u_dut8 (
    .fast_clk(clk), .rst_n(rst8), .data_on_fast_clk(d8),
    .pin_on_fast_clk(pin8), .frame_start(fs8)
  );
  output_harness #(.BITS(1)) u_dut1 (
    .fast_clk(clk), .rst_n(rst1), .data_on_fast_clk(d1),
    .pin_on_fast_clk(pin1), .frame_start(fs1)
  );
  output_harness #(.BITS(64)) u_dut64 (
    .fast_clk(clk), .rst_n(rst64), .data_on_fast_clk(d64),
    .pin_on_fast_clk(pin64), .frame_start(fs64)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Hand-computed pin sequences, index k = value after edge Ek.
  bit const_pin [20] = '{1,1,0,1,0,0,1,0,1,0, 1,0,0,0,0,0,0,0,0,0};
  bit pulse_pin [20] = '{1,0,0,0,0,0,0,0,0,0, 1,1,0,0,0,0,0,0,0,1};
  bit mid_pin   [11] = '{1,1,1,1,1,1,1,1,1,0, 1};

  logic [63:0] hist [0:10239];
  logic [63:0] cur_word;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step8(input logic r, input logic [7:0] d, input logic ep,
                       input logic ef, input string tag);
    rst8 = r;
    d8   = d;
    @(posedge clk);
    #1;
    check({tag, " pin"}, 64'(pin8), 64'(ep));
    check({tag, " fs"},  64'(fs8),  64'(ef));
  endtask

  // Receive-side view: frame f carries the XOR of every word sampled from
  // the edge after the previous start edge up to and including its own start edge.
  task automatic ref_out(input int bits, input int e, output logic p, output logic f);
    int per;
    int ph;
    logic [63:0] mask;
    per  = int'(frame_len(32'(bits)));
    ph   = e % per;
    mask = (64'd1 << bits) - 64'd1;
    f    = (ph == 0);
    if (ph == 0) begin
      cur_word = '0;
      for (int j = (e - per + 1 < 0) ? 0 : e - per + 1; j <= e; j++)
        cur_word ^= hist[j];
      cur_word &= mask;
      p = 1'b1;
    end else if (ph <= bits) begin
      p = cur_word[ph-1];
    end else begin
      p = ^cur_word;
    end
  endtask

  initial begin
    logic ep, ef;
    int   last_fs;
    rst8 = 1'b0; rst1 = 1'b0; rst64 = 1'b0;
    d8 = '0; d1 = '0; d64 = '0;
    cur_word = '0;

    // Reset hold with all-ones data.
    for (int i = 0; i < 5; i++) step8(1'b0, 8'hFF, 1'b0, 1'b0, "reset");

    // Constant 0xA5: frame 0 carries A5, frame 1 cancels to zero.
    for (int k = 0; k < 20; k++)
      step8(1'b1, 8'hA5, logic'(const_pin[k]), logic'(k % 10 == 0), "const");

    // Single pulse at E3 lands in frame 1.
    step8(1'b0, 8'h00, 1'b0, 1'b0, "rst pulse");
    for (int k = 0; k < 20; k++)
      step8(1'b1, (k == 3) ? 8'h01 : 8'h00, logic'(pulse_pin[k]),
            logic'(k % 10 == 0), "pulse");

    // Mid-frame reset while bit 4 is on the pin, then a fresh frame.
    step8(1'b0, 8'hFF, 1'b0, 1'b0, "rst mid");
    for (int k = 0; k < 6; k++)
      step8(1'b1, 8'hFF, 1'b1, logic'(k == 0), "mid pre");
    step8(1'b0, 8'hFF, 1'b0, 1'b0, "mid rst");
    for (int k = 0; k < 11; k++)
      step8(1'b1, 8'hFF, logic'(mid_pin[k]), logic'(k % 10 == 0), "mid post");
    rst8 = 1'b0;

    // BITS=1 with toggling data.
    @(posedge clk); #1;
    check("b1 reset pin", 64'(pin1), 64'd0);
    check("b1 reset fs",  64'(fs1),  64'd0);
    rst1 = 1'b1;
    for (int e = 0; e < 30; e++) begin
      d1 = (e % 2 == 0) ? 1'b1 : 1'b0;
      hist[e] = 64'(d1);
      @(posedge clk); #1;
      ref_out(1, e, ep, ef);
      check("b1 pin", 64'(pin1), 64'(ep));
      check("b1 fs",  64'(fs1),  64'(ef));
    end
    rst1 = 1'b0;

    // BITS=64 random data against the frame model.
    @(posedge clk); #1;
    rst64 = 1'b1;
    last_fs = -1;
    for (int e = 0; e < 10000; e++) begin
      d64 = {$urandom, $urandom};
      hist[e] = d64;
      @(posedge clk); #1;
      ref_out(64, e, ep, ef);
      check("b64 pin", 64'(pin64), 64'(ep));
      check("b64 fs",  64'(fs64),  64'(ef));
      if (fs64) begin
        if (last_fs >= 0) check("b64 fs period", 64'(e - last_fs), 64'd66);
        last_fs = e;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
